// File: rtl/main_state_machine_if.sv
// Handshake/strobe bundle between the PUF-core control FSM and its sub-blocks
// (UART RX/TX, challenge register, PUF array, response FIFO).
interface main_state_machine_if;
  logic tx_busy;
  logic valid_data_in;
  logic id_requested;
  logic PUF_done;
  logic empty_FIFO;
  logic store_challenge;
  logic data_sel;
  logic PUF_enable;
  logic PUF_reset;
  logic tx_enable;
  logic rx_enable;
  logic UART_reset;
  logic FIFO_reset;
  logic FIFO_re;

  modport master (
    input  tx_busy, valid_data_in, id_requested, PUF_done, empty_FIFO,
    output store_challenge, data_sel, PUF_enable, PUF_reset, tx_enable,
           rx_enable, UART_reset, FIFO_reset, FIFO_re
  );

  modport slave (
    output tx_busy, valid_data_in, id_requested, PUF_done, empty_FIFO,
    input  store_challenge, data_sel, PUF_enable, PUF_reset, tx_enable,
           rx_enable, UART_reset, FIFO_reset, FIFO_re
  );
endinterface

// File: rtl/main_state_machine.sv
// Top-level Moore control FSM of the UART-driven PUF core: optional ID reply,
// challenge capture, PUF run, then byte-by-byte drain of the response FIFO.
//
// state     | meaning
// S_RST     | sub-blocks held in reset
// S_IDLE    | listening for ID request or challenge
// S_ID_TX   | start one ID byte
// S_ID_WH   | ID byte: wait for tx_busy high
// S_ID_WL   | ID byte: wait for tx_busy low
// S_WAIT_CH | listening for challenge after ID reply
// S_STORE   | latch challenge byte
// S_PUF_CLR | one-cycle PUF reset
// S_PUF_RUN | PUF enabled until done
// S_CHECK   | FIFO empty test
// S_POP     | FIFO read strobe
// S_LAT     | extra FIFO read latency
// S_TX      | start response byte
// S_WH      | response byte: wait for tx_busy high
// S_WL      | response byte: wait for tx_busy low
// S_FINISH  | clear FIFO and PUF, back to idle
module main_state_machine #(
  parameter int ID_BYTES        = 1,
  parameter int FIFO_RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  main_state_machine_if.master bus
);

  localparam int             IdW     = (ID_BYTES > 1) ? $clog2(ID_BYTES) : 1;
  localparam logic [IdW-1:0] IdLoad  = IdW'(ID_BYTES - 1);
  localparam logic [1:0]     LatLoad = 2'((FIFO_RD_LATENCY > 1) ? FIFO_RD_LATENCY - 2 : 0);

  typedef enum logic [3:0] {
    S_RST, S_IDLE, S_ID_TX, S_ID_WH, S_ID_WL, S_WAIT_CH, S_STORE, S_PUF_CLR,
    S_PUF_RUN, S_CHECK, S_POP, S_LAT, S_TX, S_WH, S_WL, S_FINISH
  } state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] id_cnt_q, id_cnt_d;
  logic [1:0]     lat_cnt_q, lat_cnt_d;

  logic store_challenge, data_sel, puf_enable, puf_reset, tx_enable;
  logic rx_enable, uart_reset, fifo_reset, fifo_re;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_RST;
      id_cnt_q  <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      id_cnt_q  <= id_cnt_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Both counters are down-counters; zero is the terminal count.
  always_comb begin
    state_d   = state_q;
    id_cnt_d  = id_cnt_q;
    lat_cnt_d = lat_cnt_q;
    unique case (state_q)
      S_RST:     state_d = S_IDLE;
      S_IDLE: begin
        if (bus.valid_data_in) begin
          if (bus.id_requested) begin
            state_d  = S_ID_TX;
            id_cnt_d = IdLoad;
          end else begin
            state_d = S_STORE;
          end
        end
      end
      S_ID_TX:   state_d = S_ID_WH;
      S_ID_WH:   if (bus.tx_busy) state_d = S_ID_WL;
      S_ID_WL: begin
        if (!bus.tx_busy) begin
          if (id_cnt_q == '0) begin
            state_d = S_WAIT_CH;
          end else begin
            state_d  = S_ID_TX;
            id_cnt_d = id_cnt_q - IdW'(1);
          end
        end
      end
      S_WAIT_CH: if (bus.valid_data_in) state_d = S_STORE;
      S_STORE:   state_d = S_PUF_CLR;
      S_PUF_CLR: state_d = S_PUF_RUN;
      S_PUF_RUN: if (bus.PUF_done) state_d = S_CHECK;
      S_CHECK:   state_d = bus.empty_FIFO ? S_FINISH : S_POP;
      S_POP: begin
        if (FIFO_RD_LATENCY > 1) begin
          state_d   = S_LAT;
          lat_cnt_d = LatLoad;
        end else begin
          state_d = S_TX;
        end
      end
      S_LAT: begin
        if (lat_cnt_q == 2'd0) state_d = S_TX;
        else                   lat_cnt_d = lat_cnt_q - 2'd1;
      end
      S_TX:      state_d = S_WH;
      S_WH:      if (bus.tx_busy) state_d = S_WL;
      S_WL:      if (!bus.tx_busy) state_d = S_CHECK;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_RST;
    endcase
  end

  always_comb begin
    store_challenge = 1'b0;
    data_sel        = 1'b0;
    puf_enable      = 1'b0;
    puf_reset       = 1'b0;
    tx_enable       = 1'b0;
    rx_enable       = 1'b0;
    uart_reset      = 1'b0;
    fifo_reset      = 1'b0;
    fifo_re         = 1'b0;
    unique case (state_q)
      S_RST: begin
        puf_reset  = 1'b1;
        uart_reset = 1'b1;
        fifo_reset = 1'b1;
      end
      S_IDLE, S_WAIT_CH: rx_enable = 1'b1;
      S_ID_TX: begin
        data_sel  = 1'b1;
        tx_enable = 1'b1;
      end
      S_ID_WH, S_ID_WL: data_sel = 1'b1;
      S_STORE:   store_challenge = 1'b1;
      S_PUF_CLR: puf_reset = 1'b1;
      S_PUF_RUN: puf_enable = 1'b1;
      S_POP:     fifo_re = 1'b1;
      S_TX:      tx_enable = 1'b1;
      S_FINISH: begin
        fifo_reset = 1'b1;
        puf_reset  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.store_challenge = store_challenge;
  assign bus.data_sel        = data_sel;
  assign bus.PUF_enable      = puf_enable;
  assign bus.PUF_reset       = puf_reset;
  assign bus.tx_enable       = tx_enable;
  assign bus.rx_enable       = rx_enable;
  assign bus.UART_reset      = uart_reset;
  assign bus.FIFO_reset      = fifo_reset;
  assign bus.FIFO_re         = fifo_re;

endmodule

// File: tb/tb_main_state_machine.sv
// Directed bench for main_state_machine: vector tables for the control flow
// plus a modelled four-byte FIFO drain; second instance uses 2 ID bytes, latency 3.
module tb_main_state_machine;

  typedef struct {
    logic       rst_n;
    logic       busy;
    logic       valid;
    logic       idreq;
    logic       done;
    logic       empty;
    logic [8:0] exp;
  } vec_t;

  // {store, data_sel, PUF_en, PUF_rst, tx_en, rx_en, UART_rst, FIFO_rst, FIFO_re}
  localparam logic [8:0] O_RST   = 9'b000100110;
  localparam logic [8:0] O_IDLE  = 9'b000001000;
  localparam logic [8:0] O_IDTX  = 9'b010010000;
  localparam logic [8:0] O_IDW   = 9'b010000000;
  localparam logic [8:0] O_STORE = 9'b100000000;
  localparam logic [8:0] O_PCLR  = 9'b000100000;
  localparam logic [8:0] O_PRUN  = 9'b001000000;
  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_POP   = 9'b000000001;
  localparam logic [8:0] O_TX    = 9'b000010000;
  localparam logic [8:0] O_FIN   = 9'b000100010;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  main_state_machine_if bus ();
  main_state_machine_if bus2 ();

  main_state_machine #(.ID_BYTES(1), .FIFO_RD_LATENCY(1)) u_dut (
    .clk(clk), .reset(rst_n), .bus(bus.master)
  );
  main_state_machine #(.ID_BYTES(2), .FIFO_RD_LATENCY(3)) u_dut2 (
    .clk(clk), .reset(rst_n), .bus(bus2.master)
  );

  assign bus2.tx_busy       = bus.tx_busy;
  assign bus2.valid_data_in = bus.valid_data_in;
  assign bus2.id_requested  = bus.id_requested;
  assign bus2.PUF_done      = bus.PUF_done;
  assign bus2.empty_FIFO    = bus.empty_FIFO;

  logic [8:0] out1, out2;
  assign out1 = {bus.store_challenge, bus.data_sel, bus.PUF_enable, bus.PUF_reset,
                 bus.tx_enable, bus.rx_enable, bus.UART_reset, bus.FIFO_reset, bus.FIFO_re};
  assign out2 = {bus2.store_challenge, bus2.data_sel, bus2.PUF_enable, bus2.PUF_reset,
                 bus2.tx_enable, bus2.rx_enable, bus2.UART_reset, bus2.FIFO_reset, bus2.FIFO_re};

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic b, logic v, logic i, logic d, logic e, logic [8:0] x);
    vec_t t;
    t.rst_n = r; t.busy = b; t.valid = v; t.idreq = i; t.done = d; t.empty = e; t.exp = x;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n             = v.rst_n;
    bus.tx_busy       = v.busy;
    bus.valid_data_in = v.valid;
    bus.id_requested  = v.idreq;
    bus.PUF_done      = v.done;
    bus.empty_FIFO    = v.empty;
  endtask

  task automatic run_table(input string name, input vec_t tbl[$], input int sel);
    foreach (tbl[k]) begin
      drive(tbl[k]);
      @(posedge clk); #1;
      chk($sformatf("%s[%0d]", name, k), (sel == 2) ? 32'(out2) : 32'(out1), 32'(tbl[k].exp));
    end
  endtask

  vec_t tbl1[$];
  vec_t tbl_pre[$];
  vec_t tbl3[$];
  vec_t tbl2[$];

  initial begin
    int fifo_cnt, busy_left, re_seen, tx_seen, last_re, fall_at, cyc;
    bit done_flag;

    tbl1 = '{
      mk(1,0,0,0,0,0,O_IDLE),  mk(1,0,0,0,0,0,O_IDLE),  mk(1,0,1,1,0,0,O_IDTX),
      mk(1,0,0,0,0,0,O_IDW),   mk(1,0,0,0,0,0,O_IDW),   mk(1,1,0,0,0,0,O_IDW),
      mk(1,1,1,0,0,0,O_IDW),   mk(1,0,0,0,0,0,O_IDLE),  mk(1,0,0,0,0,0,O_IDLE),
      mk(1,0,1,1,0,0,O_STORE), mk(1,0,0,0,0,0,O_PCLR),  mk(1,0,0,0,0,0,O_PRUN),
      mk(1,0,1,0,0,0,O_PRUN),  mk(1,0,0,0,0,0,O_PRUN),  mk(1,0,0,0,1,0,O_NONE),
      mk(1,0,0,0,0,0,O_POP),   mk(1,0,0,0,0,0,O_TX),    mk(1,0,0,0,0,0,O_NONE),
      mk(1,0,0,0,0,0,O_NONE),  mk(1,1,0,0,0,0,O_NONE),  mk(1,1,0,0,0,0,O_NONE),
      mk(1,0,0,0,0,1,O_NONE),  mk(1,0,0,0,0,1,O_FIN),   mk(1,0,0,0,0,0,O_IDLE),
      mk(1,0,1,0,0,0,O_STORE), mk(1,0,0,0,0,0,O_PCLR),  mk(1,0,0,0,0,0,O_PRUN),
      mk(1,0,0,0,1,1,O_NONE),  mk(1,0,0,0,0,1,O_FIN),   mk(1,0,0,0,0,0,O_IDLE),
      mk(0,0,0,0,0,0,O_RST),   mk(1,0,0,0,0,0,O_IDLE)
    };
    tbl_pre = '{
      mk(1,0,1,0,0,0,O_STORE), mk(1,0,0,0,0,0,O_PCLR),  mk(1,0,0,0,0,0,O_PRUN),
      mk(1,0,0,0,0,0,O_PRUN),  mk(1,0,0,0,0,0,O_PRUN),  mk(1,0,0,0,0,0,O_PRUN),
      mk(1,0,0,0,0,0,O_PRUN),  mk(1,0,0,0,1,0,O_NONE)
    };
    tbl3 = '{
      mk(1,0,1,0,0,0,O_STORE), mk(1,0,0,0,0,0,O_PCLR),  mk(1,0,0,0,0,0,O_PRUN),
      mk(1,0,0,0,1,0,O_NONE),  mk(1,0,0,0,0,0,O_POP),   mk(1,0,0,0,0,0,O_TX),
      mk(1,1,0,0,0,0,O_NONE),  mk(1,1,0,0,0,0,O_NONE),  mk(0,1,0,0,0,0,O_RST),
      mk(0,0,0,0,0,0,O_RST),   mk(0,0,0,0,0,0,O_RST),   mk(0,0,0,0,0,0,O_RST),
      mk(1,0,0,0,0,0,O_IDLE),  mk(1,0,0,0,0,0,O_IDLE)
    };
    tbl2 = '{
      mk(0,0,0,0,0,0,O_RST),   mk(1,0,0,0,0,0,O_IDLE),  mk(1,0,1,1,0,0,O_IDTX),
      mk(1,0,0,0,0,0,O_IDW),   mk(1,1,0,0,0,0,O_IDW),   mk(1,0,0,0,0,0,O_IDTX),
      mk(1,1,0,0,0,0,O_IDW),   mk(1,1,0,0,0,0,O_IDW),   mk(1,0,0,0,0,0,O_IDLE),
      mk(1,0,1,0,0,0,O_STORE), mk(1,0,0,0,0,0,O_PCLR),  mk(1,0,0,0,0,0,O_PRUN),
      mk(1,0,0,0,1,0,O_NONE),  mk(1,0,0,0,0,0,O_POP),   mk(1,0,0,0,0,0,O_NONE),
      mk(1,0,0,0,0,0,O_NONE),  mk(1,0,0,0,0,0,O_TX),    mk(1,1,0,0,0,0,O_NONE),
      mk(1,1,0,0,0,0,O_NONE),  mk(1,0,0,0,0,1,O_NONE),  mk(1,0,0,0,0,1,O_FIN),
      mk(1,0,0,0,0,0,O_IDLE)
    };

    // Reset hold: both instances must present the reset pattern every cycle.
    drive(mk(0,0,0,0,0,0,O_RST));
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_hold[%0d]", k), 32'(out1), 32'(O_RST));
      if (k == 19) chk("rst_hold_dut2", 32'(out2), 32'(O_RST));
    end

    run_table("flow", tbl1, 1);

    // Four-byte drain with a FIFO/UART model reacting to the DUT strobes.
    run_table("drain_pre", tbl_pre, 1);
    fifo_cnt = 4; busy_left = 0; re_seen = 0; tx_seen = 0;
    last_re = -100; fall_at = -1; cyc = 0; done_flag = 0;
    drive(mk(1,0,0,0,0,0,O_NONE));
    for (int k = 0; k < 300 && !done_flag; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (out1[0]) begin
        re_seen++;
        if (fall_at >= 0) chk("busy_fall_to_re", 32'(cyc - fall_at), 32'd2);
        last_re = cyc;
        fifo_cnt--;
      end
      if (out1[4]) begin
        tx_seen++;
        chk("re_to_tx", 32'(cyc - last_re), 32'd1);
        chk("tx_data_sel", 32'(out1[7]), 32'd0);
        busy_left = 10;
      end
      if (out1[1]) begin
        chk("drain_finish", 32'(out1), 32'(O_FIN));
        done_flag = 1;
      end
      bus.empty_FIFO = (fifo_cnt == 0);
      if (busy_left > 0) begin
        bus.tx_busy = 1'b1;
        busy_left--;
      end else begin
        if (bus.tx_busy) fall_at = cyc;
        bus.tx_busy = 1'b0;
      end
    end
    chk("drain_completed", 32'(done_flag), 32'd1);
    chk("drain_re_count", 32'(re_seen), 32'd4);
    chk("drain_tx_count", 32'(tx_seen), 32'd4);
    drive(mk(1,0,0,0,0,0,O_IDLE));
    @(posedge clk); #1;
    chk("drain_idle", 32'(out1), 32'(O_IDLE));

    run_table("rst_mid_tx", tbl3, 1);
    run_table("id2_lat3", tbl2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/main_state_machine.md
Name: main_state_machine

Overview:
- Top-level control FSM of the UART-driven PUF core.
- Receives an optional ID request and a challenge byte over UART, then stores the challenge and runs the PUF.
- After the PUF finishes, drains the response FIFO byte by byte through the UART transmitter.
- Sits between the UART RX/TX, challenge register, PUF array and response FIFO; it drives their enables, strobes and resets.

Parameters:
- ID_BYTES, 1, number of ID bytes transmitted (data_sel=1) per ID request.
- FIFO_RD_LATENCY, 1, cycles from the FIFO_re pulse to the matching tx_enable pulse; legal range 1..4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- tx_busy  in  1  UART TX busy; rises after tx_enable, falls when the byte is sent.
- valid_data_in  in  1  one-cycle strobe: UART RX byte valid.
- id_requested  in  1  decoded flag, valid with valid_data_in: received byte is an ID-request command.
- store_challenge  out  1  one-cycle strobe: latch RX byte into the challenge register.
- data_sel  out  1  TX data mux select: 1 = device ID, 0 = FIFO output.
- PUF_enable  out  1  PUF run enable.
- PUF_reset  out  1  active-high PUF reset.
- PUF_done  in  1  PUF finished; may be a single-cycle pulse.
- tx_enable  out  1  one-cycle strobe: start UART transmission.
- rx_enable  out  1  UART RX listening enable.
- UART_reset  out  1  active-high UART reset.
- empty_FIFO  in  1  response FIFO empty.
- FIFO_re  out  1  one-cycle FIFO read strobe.
- FIFO_reset  out  1  active-high FIFO reset.

Behaviour:
- Moore FSM; outputs decoded from the state register only; all outputs 0 unless listed for the current state.
- reset=0 at a clock edge forces RST from any state, including mid-transmission or mid-PUF run. RST drives PUF_reset=UART_reset=FIFO_reset=1 and all other outputs 0.
- RST -> IDLE on the first edge with reset=1; the sub-block resets therefore stay high one cycle after release.
- IDLE: rx_enable=1.
  - valid_data_in & id_requested -> ID_TX.
  - valid_data_in & !id_requested -> STORE (byte is the challenge).
- ID_TX: data_sel=1, tx_enable=1 for one cycle -> ID_WH.
- ID_WH: data_sel=1; wait for tx_busy=1 -> ID_WL.
- ID_WL: data_sel=1; on tx_busy=0:
  - if fewer than ID_BYTES bytes have been sent -> ID_TX;
  - otherwise -> WAIT_CHAL.
  - Byte counter clears on entry to ID_TX from IDLE.
- WAIT_CHAL: rx_enable=1; valid_data_in -> STORE; id_requested is ignored here.
- STORE: store_challenge=1 for one cycle -> PUF_CLR.
- PUF_CLR: PUF_reset=1 for one cycle -> PUF_RUN.
- PUF_RUN: PUF_enable=1 held; PUF_done=1 sampled on any cycle -> CHECK. A single-cycle PUF_done pulse must not be missed.
- CHECK:
  - empty_FIFO=1 -> FINISH;
  - otherwise -> POP.
- POP: FIFO_re=1 for one cycle -> LAT, which waits FIFO_RD_LATENCY-1 extra cycles (0 when FIFO_RD_LATENCY=1) -> TX.
- TX: data_sel=0, tx_enable=1 for one cycle -> WH.
- WH: wait for tx_busy=1 -> WL.
- WL: wait for tx_busy=0 -> CHECK.
- FINISH: FIFO_reset=1 and PUF_reset=1 for one cycle -> IDLE.
- Latencies:
  - valid byte in IDLE/WAIT_CHAL to store_challenge: 1 cycle.
  - FIFO_re to tx_enable: FIFO_RD_LATENCY cycles.
  - tx_busy fall to the next FIFO_re (FIFO non-empty): 2 cycles.
- valid_data_in outside IDLE/WAIT_CHAL is ignored.
- tx_busy already high when entering WH/ID_WH counts as busy seen.
- tx_enable, FIFO_re and store_challenge are never high for two consecutive cycles.
- No timeouts: a missing tx_busy or PUF_done holds the FSM until reset.
- FIFO empty on first CHECK: no bytes are sent; go directly to FINISH.

Test Plan:
- Reset: hold reset=0 for 20 cycles -> PUF_reset=UART_reset=FIFO_reset=1, all other outputs 0. Release -> those resets fall one cycle later; rx_enable=1.
- ID request flow: in IDLE, pulse valid_data_in with id_requested=1 -> rx_enable falls; one tx_enable pulse with data_sel=1. Bench raises tx_busy 1 cycle later for 10 cycles -> rx_enable rises after tx_busy falls.
- Challenge capture and PUF run: in WAIT_CHAL pulse valid_data_in -> store_challenge 1 cycle later, then a one-cycle PUF_reset, then PUF_enable held. Pulse PUF_done for one cycle 5 cycles later -> PUF_enable drops next cycle.
- FIFO drain: FIFO holds 4 bytes (empty_FIFO set after the 4th FIFO_re) -> exactly 4 FIFO_re pulses, each followed one cycle later by tx_enable with data_sel=0; each next FIFO_re comes 2 cycles after tx_busy falls. Then one-cycle FIFO_reset+PUF_reset, then IDLE (rx_enable=1).
- Direct challenge: in IDLE pulse valid_data_in with id_requested=0 -> no tx_enable; store_challenge next cycle.
- Reset mid-transmission: assert reset=0 while in WL -> RST on the next edge; tx_enable stays 0; no further FIFO_re.
